// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
package seg7_pkg;

  typedef logic [4:0] glyph_t;

  localparam glyph_t     CODE_DASH  = 5'd16;
  localparam glyph_t     CODE_BLANK = 5'd17;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// Glyph code to active-low GFEDCBA segment pattern. Codes 0..15 are hex,
// 16 is a dash, everything else is blank.
module seg7_decoder
  import seg7_pkg::*;
(
  input  glyph_t     code,
  output logic [6:0] seg
);

  // Pure lookup; unknown codes fall through to blank.
  always_comb begin
    seg = SEG_OFF;
    case (code)
      5'd0:      seg = 7'h40;
      5'd1:      seg = 7'h79;
      5'd2:      seg = 7'h24;
      5'd3:      seg = 7'h30;
      5'd4:      seg = 7'h19;
      5'd5:      seg = 7'h12;
      5'd6:      seg = 7'h02;
      5'd7:      seg = 7'h78;
      5'd8:      seg = 7'h00;
      5'd9:      seg = 7'h10;
      5'd10:     seg = 7'h08;
      5'd11:     seg = 7'h03;
      5'd12:     seg = 7'h46;
      5'd13:     seg = 7'h21;
      5'd14:     seg = 7'h06;
      5'd15:     seg = 7'h0E;
      CODE_DASH: seg = 7'h3F;
      default:   seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode seven-segment driver. An internal prescaler
// dwells on each digit for DWELL cycles; all per-digit inputs are sampled
// once per frame so a frame never shows a torn value. Outputs are
// registered one cycle behind the counter state they describe.
module seven_segment_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL        = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int BRIGHT_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5*NUM_DIGITS-1:0] codes,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   DIGIT,
  output logic [6:0]              DISPLAY,
  output logic                    DP,
  output logic                    frame_start
);

  localparam int DW       = $clog2(DWELL);
  localparam int IW       = $clog2(NUM_DIGITS);
  localparam int SLOT_LEN = DWELL >> BRIGHT_W;
  localparam int SW       = $clog2(SLOT_LEN);
  localparam int FW       = $clog2(BLINK_FRAMES + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] SUB_LAST   = SW'(SLOT_LEN - 1);
  localparam logic [FW-1:0] BF_LAST    = FW'(BLINK_FRAMES - 1);

  // Scan counters. slot tracks dwell_cnt / SLOT_LEN incrementally so no
  // divider is needed for non-power-of-two dwell lengths.
  logic [DW-1:0]       dwell_cnt;
  logic [SW-1:0]       sub_cnt;
  logic [BRIGHT_W-1:0] slot;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       frame_cnt;
  logic                blink_phase;

  // Per-frame shadow copies of the inputs.
  glyph_t                shadow_codes [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [NUM_DIGITS-1:0] shadow_blink;
  logic [NUM_DIGITS-1:0] shadow_lz;
  logic [BRIGHT_W-1:0]   shadow_bright;

  logic dwell_wrap;
  logic last_digit;
  logic frame_wrap;
  logic snapshot;

  assign dwell_wrap = (dwell_cnt == DWELL_LAST);
  assign last_digit = (idx == IDX_LAST);
  assign frame_wrap = dwell_wrap && last_digit;
  assign snapshot   = (dwell_cnt == '0) && (idx == '0);

  // Prescaler, brightness slot and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      sub_cnt   <= '0;
      slot      <= '0;
      idx       <= '0;
    end else if (dwell_wrap) begin
      dwell_cnt <= '0;
      sub_cnt   <= '0;
      slot      <= '0;
      idx       <= last_digit ? '0 : idx + 1'b1;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
      if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        slot    <= slot + 1'b1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

  // Blink phase flips after every BLINK_FRAMES complete frames; the flip
  // lands on a frame boundary, where the anodes are already dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_wrap) begin
      if (frame_cnt == BF_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Leading-zero mask from the live inputs: a zero digit is blanked while
  // every digit above it is zero or blank-coded. Digit 0 always shows.
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  higher_clear;
  glyph_t                lz_code;

  always_comb begin
    lz_mask      = '0;
    higher_clear = 1'b1;
    lz_code      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_code = codes[5*i +: 5];
      if ((i != 0) && (lz_code == 5'd0) && higher_clear) lz_mask[i] = 1'b1;
      higher_clear = higher_clear && ((lz_code == 5'd0) || (lz_code >= CODE_BLANK));
    end
  end

  // Frame snapshot of every display input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow_codes[i] <= CODE_BLANK;
      shadow_dp     <= '0;
      shadow_blink  <= '0;
      shadow_lz     <= '0;
      shadow_bright <= '0;
    end else if (snapshot) begin
      for (int i = 0; i < NUM_DIGITS; i++) shadow_codes[i] <= codes[5*i +: 5];
      shadow_dp     <= dp_en;
      shadow_blink  <= blink_en;
      shadow_lz     <= lz_suppress ? lz_mask : '0;
      shadow_bright <= brightness;
    end
  end

  // Current digit: blinked or suppressed digits decode as blank.
  logic       blinked;
  logic       hidden;
  glyph_t     dec_code;
  logic [6:0] seg;
  logic       anode_on;

  assign blinked  = blink_phase && shadow_blink[idx];
  assign hidden   = blinked || shadow_lz[idx];
  assign dec_code = hidden ? CODE_BLANK : shadow_codes[idx];
  // Cycle 0 of every dwell stays dark so the previous digit cannot ghost.
  assign anode_on = (dwell_cnt != '0) && (slot <= shadow_bright);

  seg7_decoder u_decoder (
    .code (dec_code),
    .seg  (seg)
  );

  // Registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DIGIT       <= '1;
      DISPLAY     <= SEG_OFF;
      DP          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= snapshot;
      if (anode_on) begin
        DIGIT   <= ~(NUM_DIGITS'(1) << idx);
        DISPLAY <= seg;
        DP      <= ~(shadow_dp[idx] && !blinked);
      end else begin
        DIGIT   <= '1;
        DISPLAY <= SEG_OFF;
        DP      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: one 4-digit and one 8-digit instance,
// DWELL=16, BRIGHT_W=3, BLINK_FRAMES=2. Each dwell window is summarised
// (frame_start count, anode pattern, segments, DP, on-cycle count and last
// on position) and compared against a queued expectation.
module tb_seven_segment_scanner;

  localparam int W = 29;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [19:0] codes4;
  logic [3:0]  dp4, blk4;
  logic [2:0]  bright4;
  logic        lz4;
  logic [3:0]  digit4;
  logic [6:0]  disp4;
  logic        dpo4, fs4;

  logic [39:0] codes8;
  logic [7:0]  dp8, blk8;
  logic [2:0]  bright8;
  logic        lz8;
  logic [7:0]  digit8;
  logic [6:0]  disp8;
  logic        dpo8, fs8;

  seven_segment_scanner #(.NUM_DIGITS(4), .DWELL(16), .BLINK_FRAMES(2), .BRIGHT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .codes(codes4), .dp_en(dp4), .blink_en(blk4),
    .brightness(bright4), .lz_suppress(lz4), .DIGIT(digit4), .DISPLAY(disp4),
    .DP(dpo4), .frame_start(fs4)
  );

  seven_segment_scanner #(.NUM_DIGITS(8), .DWELL(16), .BLINK_FRAMES(2), .BRIGHT_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .codes(codes8), .dp_en(dp8), .blink_en(blk8),
    .brightness(bright8), .lz_suppress(lz8), .DIGIT(digit8), .DISPLAY(disp8),
    .DP(dpo8), .frame_start(fs8)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Clock edges since reset release; frame n starts showing at cyc = 1+64n.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic [19:0] codes;
    logic [3:0]  dp;
    logic [2:0]  bright;
    logic        lz;
    logic [27:0] disp;    // expected segments {d3,d2,d1,d0}
    logic [3:0]  dp_out;  // expected active-low DP per digit
    int          on;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [W-1:0] pack(input logic [1:0] fs, input logic ok,
                                        input logic [7:0] dg, input logic [6:0] ds,
                                        input logic dp, input logic [4:0] cnt,
                                        input logic [4:0] last);
    return {fs, ok, dg, ds, dp, cnt, last};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, "_4"}, W'({8'hF0 | {4'h0, digit4}, disp4, dpo4, fs4}), W'({8'hFF, 7'h7F, 1'b1, 1'b0}));
    check({name, "_8"}, W'({digit8, disp8, dpo8, fs8}), W'({8'hFF, 7'h7F, 1'b1, 1'b0}));
  endtask

  // Queue one expected record per dwell of the next frame.
  task automatic push_frame(input int nd, input logic [55:0] disp, input logic [7:0] dp_out, input int on);
    for (int d = 0; d < nd; d++)
      exp_q.push_back(pack((d == 0) ? 2'd1 : 2'd0, 1'b1, 8'hFF & ~(8'd1 << d),
                           disp[7*d +: 7], dp_out[d], 5'(on), 5'(on)));
  endtask

  task automatic wait_frame(input bit sel8);
    int k = 0;
    logic fs;
    do begin
      @(negedge clk);
      k++;
      fs = sel8 ? fs8 : fs4;
    end while (!fs && k < 400);
    if (!fs) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_wait: no frame_start within %0d cycles", k);
    end
  endtask

  // Observe one 16-cycle dwell window starting at the current negedge and
  // compare its summary with the head of the expectation queue.
  task automatic observe_dwell(input bit sel8, input int chg_pos, input logic [19:0] chg_codes,
                               input string name);
    int fs_cnt = 0, cnt = 0, last = 0;
    logic ok = 1'b1;
    logic [7:0] dg = 8'hFF, sd;
    logic [6:0] ds = 7'h7F, sds;
    logic dp = 1'b1, sdp, sfs;
    logic [W-1:0] e;
    for (int p = 0; p < 16; p++) begin
      if (p > 0) @(negedge clk);
      sd  = sel8 ? digit8 : {4'hF, digit4};
      sds = sel8 ? disp8 : disp4;
      sdp = sel8 ? dpo8 : dpo4;
      sfs = sel8 ? fs8 : fs4;
      if (sfs) fs_cnt++;
      if (sd != 8'hFF) begin
        if (p == 0) ok = 1'b0;
        if (cnt > 0 && {sd, sds, sdp} != {dg, ds, dp}) ok = 1'b0;
        dg = sd; ds = sds; dp = sdp;
        cnt++;
        last = p;
      end else if (sds != 7'h7F || sdp != 1'b1) begin
        ok = 1'b0;
      end
      if (p == chg_pos) codes4 = chg_codes;
    end
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no expectation queued", name);
    end else begin
      e = exp_q.pop_front();
      check(name, pack(2'(fs_cnt), ok, dg, ds, dp, 5'(cnt), 5'(last)), e);
    end
  endtask

  task automatic drive4(input vec_t v);
    codes4  = v.codes;
    dp4     = v.dp;
    blk4    = 4'b0000;
    bright4 = v.bright;
    lz4     = v.lz;
  endtask

  initial begin
    vecs[0] = '{codes:{5'd3,5'd2,5'd1,5'd0},    dp:4'b0000, bright:3'd7, lz:1'b0,
                disp:{7'h30,7'h24,7'h79,7'h40}, dp_out:4'b1111, on:15};
    vecs[1] = '{codes:{5'd0,5'd0,5'd5,5'd0},    dp:4'b0000, bright:3'd7, lz:1'b1,
                disp:{7'h7F,7'h7F,7'h12,7'h40}, dp_out:4'b1111, on:15};
    vecs[2] = '{codes:{5'd0,5'd0,5'd0,5'd0},    dp:4'b0000, bright:3'd7, lz:1'b1,
                disp:{7'h7F,7'h7F,7'h7F,7'h40}, dp_out:4'b1111, on:15};
    vecs[3] = '{codes:{5'd0,5'd0,5'd0,5'd0},    dp:4'b0000, bright:3'd7, lz:1'b0,
                disp:{7'h40,7'h40,7'h40,7'h40}, dp_out:4'b1111, on:15};
    vecs[4] = '{codes:{5'd15,5'd14,5'd13,5'd12}, dp:4'b0000, bright:3'd0, lz:1'b0,
                disp:{7'h0E,7'h06,7'h21,7'h46}, dp_out:4'b1111, on:1};
    vecs[5] = '{codes:{5'd9,5'd8,5'd7,5'd6},    dp:4'b0000, bright:3'd3, lz:1'b0,
                disp:{7'h10,7'h00,7'h78,7'h02}, dp_out:4'b1111, on:7};
    vecs[6] = '{codes:{5'd20,5'd0,5'd16,5'd0},  dp:4'b0000, bright:3'd7, lz:1'b1,
                disp:{7'h7F,7'h7F,7'h3F,7'h40}, dp_out:4'b1111, on:15};
    vecs[7] = '{codes:{5'd0,5'd4,5'd0,5'd0},    dp:4'b1000, bright:3'd5, lz:1'b1,
                disp:{7'h7F,7'h19,7'h40,7'h40}, dp_out:4'b0111, on:11};
    vecs[8] = '{codes:{5'd11,5'd17,5'd31,5'd0}, dp:4'b0101, bright:3'd7, lz:1'b1,
                disp:{7'h03,7'h7F,7'h7F,7'h40}, dp_out:4'b1010, on:15};

    // Clock/reset.
    rst_n   = 1'b1;
    drive4(vecs[0]);
    codes8  = {5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'd20, 5'd16, 5'd10};
    dp8     = 8'h00;
    blk8    = 8'h00;
    bright8 = 3'd7;
    lz8     = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors, one full frame each.
    for (int v = 0; v < 9; v++) begin
      drive4(vecs[v]);
      wait_frame(1'b0);
      push_frame(4, {28'h0, vecs[v].disp}, {4'hF, vecs[v].dp_out}, vecs[v].on);
      for (int d = 0; d < 4; d++)
        observe_dwell(1'b0, -1, 20'h0, $sformatf("vec%0d_dwell%0d", v, d));
    end

    // Snapshot coherence: codes change at cycle 20 of a frame.
    drive4(vecs[0]);
    wait_frame(1'b0);
    push_frame(4, {28'h0, vecs[0].disp}, 8'hFF, 15);
    for (int d = 0; d < 4; d++)
      observe_dwell(1'b0, (d == 1) ? 4 : -1, {5'd1, 5'd2, 5'd3, 5'd4},
                    $sformatf("coh_old_dwell%0d", d));
    push_frame(4, {28'h0, 7'h79, 7'h24, 7'h30, 7'h19}, 8'hFF, 15);
    for (int d = 0; d < 4; d++)
      observe_dwell(1'b0, -1, 20'h0, $sformatf("coh_new_dwell%0d", d));

    // Asynchronous reset in the middle of a lit dwell.
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async");
    @(negedge clk);
    check_reset("reset_held");

    // Blink and DP on digit 1 across four frames.
    drive4(vecs[0]);
    blk4 = 4'b0010;
    dp4  = 4'b0010;
    rst_n = 1'b1;
    wait_frame(1'b0);
    for (int f = 0; f < 4; f++) begin
      int n;
      bit ph;
      n  = (cyc - 1) / 64;
      ph = ((n / 2) % 2) == 1;
      push_frame(4, {28'h0, 7'h30, 7'h24, ph ? 7'h7F : 7'h79, 7'h40},
                 {6'h3F, ph ? 1'b1 : 1'b0, 1'b1}, 15);
      for (int d = 0; d < 4; d++)
        observe_dwell(1'b0, -1, 20'h0, $sformatf("blink_f%0d_dwell%0d", f, d));
    end

    // Eight-digit instance: letter, dash, blank and hex, all anodes.
    wait_frame(1'b1);
    push_frame(8, {7'h19, 7'h30, 7'h24, 7'h79, 7'h40, 7'h7F, 7'h3F, 7'h08}, 8'hFF, 15);
    for (int d = 0; d < 8; d++)
      observe_dwell(1'b1, -1, 20'h0, $sformatf("wide_dwell%0d", d));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Parametrised multiplexed seven-segment driver, the successor to the fixed 4-digit controller. It scans `NUM_DIGITS` common-anode digits from an internal dwell prescaler, so no external display clock is needed. Each frame it snapshots per-digit glyph codes and decodes hex, dash and blank glyphs. It adds decimal points, per-digit blink, PWM brightness and leading-zero suppression. It sits between the application's status registers (volume, octave, loop width, etc.) and the board's anode/segment pins.

## Interface
- `NUM_DIGITS`, default 4: digit count, legal range 2..8.
- `DWELL`, default 50000: clock cycles each digit is selected. Must be a multiple of 2^`BRIGHT_W` and at least 2·2^`BRIGHT_W`.
- `BLINK_FRAMES`, default 64: frames per blink half-period, at least 1.
- `BRIGHT_W`, default 3: brightness control width.
- `clk`  in  1: single system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `codes`  in  5·NUM_DIGITS: glyph code per digit, digit i at [5i+4:5i]. Digit 0 is rightmost.
- `dp_en`  in  NUM_DIGITS: decimal point on, per digit.
- `blink_en`  in  NUM_DIGITS: blink enable, per digit.
- `brightness`  in  BRIGHT_W: duty select; 0 = minimum, all-ones = maximum.
- `lz_suppress`  in  1: enables leading-zero blanking.
- `DIGIT`  out  NUM_DIGITS: anode select, active-low, one-hot-low.
- `DISPLAY`  out  7: segments GFEDCBA, active-low.
- `DP`  out  1: decimal point, active-low.
- `frame_start`  out  1: one-cycle pulse marking the start of a frame.

## Operation
- `dwell_cnt` counts 0..DWELL-1 and wraps.
- On wrap, `idx` advances 0..NUM_DIGITS-1 and wraps to 0.
- Snapshot point: `dwell_cnt`==0 and `idx`==0, including the first cycle after reset.
  - At this point `codes`, `dp_en`, `blink_en`, `brightness` and `lz_suppress` are latched into shadow registers.
  - Input changes inside a frame are invisible until the next frame.
- Glyph codes:
  - 0..15 display hex 0-9, A, b, C, d, E, F.
  - 16 displays a dash (segment G only).
  - 17..31 display blank.
- Leading-zero suppression is computed at snapshot time.
  - A digit whose code is 0 is blanked if every higher-index digit is 0 or blank-coded (17..31).
  - Digit 0 is never suppressed.
  - DP of a suppressed digit still follows `dp_en`.
- Blink:
  - A `blink_phase` bit toggles each time the frame counter reaches BLINK_FRAMES, and the counter then restarts.
  - While `blink_phase`=1, digits with shadow `blink_en` set show blank segments and DP off. Their anode stays driven.
- Brightness:
  - `slot` = `dwell_cnt` / (DWELL >> BRIGHT_W).
  - The selected anode is asserted only when `slot` ≤ shadow `brightness`.
- Anti-ghost rule: all anodes are off whenever `dwell_cnt`==0, regardless of brightness.
- When an anode is off, `DISPLAY` = 7'h7F and `DP` = 1.
- Reset values:
  - Outputs: `DIGIT` all ones, `DISPLAY` 7'h7F, `DP` 1, `frame_start` 0.
  - Internal state: counters 0, `blink_phase` 0, shadow codes 17 (blank), shadow `dp_en` and `blink_en` 0.
- Reset asserted mid-frame returns every output to its reset value immediately, with no clock edge required.

## Timing
- All outputs are registered and reflect counter state with exactly one cycle of latency.
- `frame_start` is high for one cycle, in the cycle after the snapshot cycle.
- Input-to-display latency ranges from 1 to NUM_DIGITS·DWELL+1 cycles, depending on where the snapshot point falls.
- Frame period: NUM_DIGITS·DWELL cycles.
- Blink period: 2·BLINK_FRAMES frames.
- On-time per dwell: (brightness+1)·DWELL/2^BRIGHT_W − 1 cycles. The −1 is the anti-ghost cycle.
- `DIGIT` never has more than one bit low in any cycle.

## Structure
- Package `seg7_pkg` holds:
  - `CODE_DASH`=5'd16 and `CODE_BLANK`=5'd17.
  - `SEG_OFF`=7'h7F.
  - A `glyph_t` 5-bit typedef.
- Sub-module `seg7_decoder`: purely combinational, mapping a 5-bit code to 7-bit active-low GFEDCBA. It is instantiated once, on the muxed current digit.
- Top level contains the prescaler, `idx`, frame and blink counters, shadow registers, LZ mask generation, PWM compare and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, DWELL=16, BRIGHT_W=3, BLINK_FRAMES=2 unless noted.
- Scan and reset:
  - Stimulus: `codes`={3,2,1,0}, brightness 7.
  - Required: `DIGIT` walks 1110→1101→1011→0111 every 16 cycles, each preceded by one all-ones cycle.
  - Required: `DISPLAY` shows 7'h40, 7'h79, 7'h24, 7'h30 respectively.
  - Required: `frame_start` pulses every 64 cycles.
  - Stimulus: `rst_n`=0 mid-scan. Required: all outputs return to reset values asynchronously.
- Snapshot coherence:
  - Stimulus: change `codes` at cycle 20 of a frame.
  - Required: the current frame still displays the old values; the new values appear from the next frame, after `frame_start`.
- Leading-zero suppression:
  - Stimulus: `codes`={0,0,5,0}, `lz_suppress`=1.
  - Required: digits 3 and 2 are blank; digit 1 shows 5; digit 0 shows 0.
  - Stimulus: `codes`={0,0,0,0}. Required: only digit 0 shows 0.
- Brightness:
  - Stimulus: brightness 0. Required: each anode is low for exactly 1 cycle per dwell (cycle 1).
  - Stimulus: brightness 3. Required: each anode is low for 7 cycles per dwell.
- Blink and DP:
  - Stimulus: `blink_en`=4'b0010, `dp_en`=4'b0010.
  - Required: digit 1's segments and DP alternate visible/blank every 2 frames, while the anode timing is unchanged.
  - Required: other digits are never blanked.
- Glyphs and width:
  - Stimulus: NUM_DIGITS=8, codes 10, 16 and 20.
  - Required: `DISPLAY` shows 7'h08 (A), 7'h3F (dash) and 7'h7F (blank).
  - Required: the anode pattern cycles through all 8 digits.
